// File: rtl/scpad_head_arbiter_pkg.sv
// scpad_head_arbiter_pkg: request types and packing helper shared by the scratchpad head arbiter.
package scpad_head_arbiter_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;
  localparam int SCPAD_W = 4;
  typedef enum logic {SRC_FE = 1'b0, SRC_BE = 1'b1} src_e;
  typedef struct packed {
    logic valid;
    logic write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } req_t;
  typedef struct packed {
    logic valid;
    src_e src;
    logic [SCPAD_W-1:0] scpad;
    logic write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } sel_req_t;
  localparam int REQ_W = $bits(req_t);
  localparam int SEL_W = $bits(sel_req_t);
  function automatic sel_req_t to_sel(req_t r, src_e s, logic [SCPAD_W-1:0] id);
    return '{valid: 1'b1, src: s, scpad: id, write: r.write, addr: r.addr, data: r.data, mask: r.mask};
  endfunction
endpackage

// File: rtl/scpad_head_arbiter_prio.sv
// scpad_head_arbiter_prio: BE-over-FE fixed priority with a starvation counter that forces FE ahead.
module scpad_head_arbiter_prio
  import scpad_head_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic fe_valid_i,
  input  logic be_valid_i,
  input  logic can_accept_i,
  output logic grant_fe_o,
  output logic grant_be_o
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic force_fe;
  // A BE grant with FE pending implies the limit is not yet reached, so counting saturates naturally.
  always_comb begin
    force_fe = starve_cnt_q == CW'(STARVE_LIMIT);
    grant_fe_o = can_accept_i & fe_valid_i & (!be_valid_i | force_fe);
    grant_be_o = can_accept_i & be_valid_i & !(fe_valid_i & force_fe);
    starve_cnt_d = (!fe_valid_i || grant_fe_o) ? '0 : grant_be_o ? starve_cnt_q + 1'b1 : starve_cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) starve_cnt_q <= '0;
    else starve_cnt_q <= starve_cnt_d;
endmodule

// File: rtl/scpad_head_arbiter.sv
// scpad_head_arbiter: merges FE and BE requests into one registered request honouring per-class stalls.
module scpad_head_arbiter
  import scpad_head_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int SCPAD_ID = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic [REQ_W-1:0] fe_req,
  input  logic [REQ_W-1:0] be_req,
  input  logic w_stall,
  input  logic r_stall,
  output logic fe_stall,
  output logic be_stall,
  output logic [SEL_W-1:0] head_stomach_req
);
  req_t fe, be;
  sel_req_t out_q, out_d;
  logic out_stalled, can_accept, grant_fe, grant_be;
  assign fe = req_t'(fe_req);
  assign be = req_t'(be_req);
  assign out_stalled = out_q.valid & (out_q.write ? w_stall : r_stall);
  assign can_accept = !rst & !out_stalled;
  scpad_head_arbiter_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk(clk),
    .rst(rst),
    .fe_valid_i(fe.valid),
    .be_valid_i(be.valid),
    .can_accept_i(can_accept),
    .grant_fe_o(grant_fe),
    .grant_be_o(grant_be)
  );
  // A drain and a fresh load may coincide, giving back-to-back requests without a bubble.
  always_comb begin
    out_d = grant_fe ? to_sel(fe, SRC_FE, SCPAD_W'(SCPAD_ID)) :
            grant_be ? to_sel(be, SRC_BE, SCPAD_W'(SCPAD_ID)) :
            sel_req_t'({out_q.valid & out_stalled, out_q[SEL_W-2:0]});
    fe_stall = fe.valid & !grant_fe;
    be_stall = be.valid & !grant_be;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) out_q <= '0;
    else out_q <= out_d;
  assign head_stomach_req = out_q;
endmodule

// File: tb/tb_scpad_head_arbiter.sv
// tb_scpad_head_arbiter: vector table, hand sequences and randomized traffic against a reference model.
module tb_scpad_head_arbiter;
  import scpad_head_arbiter_pkg::*;
  localparam int LIM = 8;
  localparam int ID = 3;
  typedef struct {
    bit fv, fw, bv, bw, ws, rs, efs, ebs, ev;
    src_e es;
    bit eld;
  } vec_t;
  logic clk = 1'b0;
  logic rst, w_stall, r_stall, fe_stall, be_stall;
  logic [SEL_W-1:0] head_stomach_req;
  req_t fr, br;
  sel_req_t out;
  int n_chk = 0, n_fail = 0;
  bit s_fs, s_bs;
  bit m_valid, m_blocked, m_fs, m_bs;
  sel_req_t m_item;
  int m_wait, m_pick;
  vec_t tab[24];
  sel_req_t exp_out;
  always #5 clk = ~clk;
  assign out = sel_req_t'(head_stomach_req);
  scpad_head_arbiter #(.STARVE_LIMIT(LIM), .SCPAD_ID(ID)) dut (
    .clk(clk),
    .rst(rst),
    .fe_req(fr),
    .be_req(br),
    .w_stall(w_stall),
    .r_stall(r_stall),
    .fe_stall(fe_stall),
    .be_stall(be_stall),
    .head_stomach_req(head_stomach_req)
  );
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  function automatic req_t mk(bit v, bit w, logic [15:0] a);
    return '{valid: v, write: w, addr: a, data: {a, ~a}, mask: a[3:0]};
  endfunction
  function automatic sel_req_t pack(req_t r, src_e s);
    sel_req_t p;
    p.valid = 1'b1;
    p.src = s;
    p.scpad = SCPAD_W'(ID);
    p.write = r.write;
    p.addr = r.addr;
    p.data = r.data;
    p.mask = r.mask;
    return p;
  endfunction
  function automatic vec_t row(bit fv, fw, bv, bw, ws, rs, efs, ebs, ev, src_e es, bit eld);
    return '{fv: fv, fw: fw, bv: bv, bw: bw, ws: ws, rs: rs, efs: efs, ebs: ebs, ev: ev, es: es, eld: eld};
  endfunction
  // Reference: one-entry holding slot, a FE wait counter, and the priority rules applied per cycle.
  task automatic cyc(input req_t f, input req_t b, input logic ws, input logic rs, input bit um);
    fr = f;
    br = b;
    w_stall = ws;
    r_stall = rs;
    #1;
    s_fs = fe_stall;
    s_bs = be_stall;
    m_blocked = m_valid && (m_item.write ? ws : rs);
    if (rst || m_blocked) m_pick = 0;
    else if (f.valid && b.valid) m_pick = (m_wait >= LIM) ? 1 : 2;
    else m_pick = f.valid ? 1 : b.valid ? 2 : 0;
    m_fs = f.valid && m_pick != 1;
    m_bs = b.valid && m_pick != 2;
    if (um) begin
      chk("fe_stall", 64'(s_fs), 64'(m_fs));
      chk("be_stall", 64'(s_bs), 64'(m_bs));
    end
    @(posedge clk);
    if (m_pick == 1) begin
      m_item = pack(f, SRC_FE);
      m_valid = 1;
      m_wait = 0;
    end else if (m_pick == 2) begin
      m_item = pack(b, SRC_BE);
      m_valid = 1;
      m_wait = f.valid ? ((m_wait + 1 > LIM) ? LIM : m_wait + 1) : 0;
    end else begin
      if (!m_blocked) m_valid = 0;
      if (!f.valid) m_wait = 0;
    end
    @(negedge clk);
    if (um) begin
      chk("out_valid", 64'(out.valid), 64'(m_valid));
      if (m_valid) chk("out_req", 64'(out), 64'(m_item));
    end
  endtask
  initial begin
    for (int i = 0; i < 8; i++) tab[i] = row(1, 0, 1, 0, 0, 0, 1, 0, 1, SRC_BE, 1);
    tab[8] = row(1, 0, 1, 0, 0, 0, 0, 1, 1, SRC_FE, 1);
    tab[9] = row(1, 0, 1, 1, 0, 0, 1, 0, 1, SRC_BE, 1);
    for (int i = 10; i < 15; i++) tab[i] = row(1, 0, 1, 0, 1, 1'(i & 1), 1, 1, 1, SRC_BE, 0);
    tab[15] = row(1, 0, 1, 0, 0, 0, 1, 0, 1, SRC_BE, 1);
    tab[16] = row(0, 0, 1, 0, 0, 0, 0, 0, 1, SRC_BE, 1);
    tab[17] = row(0, 0, 0, 0, 1, 0, 0, 0, 0, SRC_FE, 0);
    tab[18] = row(1, 1, 0, 0, 1, 0, 0, 0, 1, SRC_FE, 1);
    tab[19] = row(1, 1, 0, 0, 1, 0, 1, 0, 1, SRC_FE, 0);
    tab[20] = row(1, 0, 0, 0, 0, 1, 0, 0, 1, SRC_FE, 1);
    tab[21] = row(1, 0, 0, 0, 0, 1, 1, 0, 1, SRC_FE, 0);
    tab[22] = row(0, 0, 0, 0, 0, 1, 0, 0, 1, SRC_FE, 0);
    tab[23] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, SRC_FE, 0);
    exp_out = '0;
    rst = 1'b1;
    fr = '0;
    br = '0;
    w_stall = 1'b0;
    r_stall = 1'b0;
    m_valid = 0;
    m_wait = 0;
    repeat (2) @(negedge clk);
    fr = mk(1, 0, 16'h1111);
    br = mk(1, 1, 16'h2222);
    #1;
    chk("rst_fe_stall", 64'(fe_stall), 64'(1));
    chk("rst_be_stall", 64'(be_stall), 64'(1));
    chk("rst_valid", 64'(out.valid), 64'(0));
    rst = 1'b0;
    cyc(mk(1, 0, 16'h1111), mk(1, 1, 16'h2222), 0, 0, 1);
    chk("first_valid", 64'(out.valid), 64'(1));
    chk("first_src", 64'(out.src), 64'(SRC_BE));
    cyc('0, '0, 0, 0, 1);
    for (int i = 0; i < 24; i++) begin
      req_t f, b;
      f = mk(tab[i].fv, tab[i].fw, 16'h1000 + 16'(i));
      b = mk(tab[i].bv, tab[i].bw, 16'h2000 + 16'(i));
      cyc(f, b, tab[i].ws, tab[i].rs, 0);
      chk($sformatf("tab%0d_fe_stall", i), 64'(s_fs), 64'(tab[i].efs));
      chk($sformatf("tab%0d_be_stall", i), 64'(s_bs), 64'(tab[i].ebs));
      chk($sformatf("tab%0d_valid", i), 64'(out.valid), 64'(tab[i].ev));
      if (tab[i].eld) exp_out = pack(tab[i].es == SRC_BE ? b : f, tab[i].es);
      if (tab[i].ev) chk($sformatf("tab%0d_out", i), 64'(out), 64'(exp_out));
    end
    for (int i = 0; i < 20; i++) begin
      cyc(mk(1, 1'($urandom_range(0, 1)), 16'($urandom)), '0, 0, 0, 1);
      chk("fe_only_src", 64'(out.src), 64'(SRC_FE));
    end
    for (int i = 0; i < 5; i++) cyc(mk(1, 0, 16'h3000 + 16'(i)), mk(1, 0, 16'h4000 + 16'(i)), 0, 0, 1);
    cyc(mk(1, 0, 16'h3100), mk(1, 0, 16'h4100), 0, 1, 1);
    cyc(mk(1, 0, 16'h3100), mk(1, 0, 16'h4101), 0, 1, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out.valid), 64'(0));
    chk("mid_rst_fe_stall", 64'(fe_stall), 64'(1));
    chk("mid_rst_be_stall", 64'(be_stall), 64'(1));
    m_valid = 0;
    m_wait = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      cyc(mk(1, 0, 16'h5000 + 16'(k)), mk(1, 1, 16'h6000 + 16'(k)), 0, 0, 1);
      chk($sformatf("post_rst_src%0d", k), 64'(out.src), 64'(k == 8 ? SRC_FE : SRC_BE));
    end
    for (int i = 0; i < 400; i++)
      cyc(mk($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 16'($urandom)),
          mk($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 16'($urandom)),
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
